// File: rtl/tx_stream_arbiter.sv
// tx_stream_arbiter
//   Packet-locked round-robin arbiter. Several byte-stream sources share one
//   SPI TX channel. A grant is held for a whole packet, which ends on a word
//   accepted with s_last high. The output word is held in a single register
//   stage toward the SPI TX queue.
//
// Ports
//   clk_system   single clock, rising edge
//   rstn_system  asynchronous active-low reset
//   s_valid      per-requester word valid                 [NUM_REQUESTERS]
//   s_ready      per-requester word accepted              [NUM_REQUESTERS]
//   s_data       requester i word at [i*WORD_SIZE +: WORD_SIZE]
//   s_last       per-requester end-of-packet flag         [NUM_REQUESTERS]
//   m_valid      output word valid
//   m_ready      downstream accepts output word
//   m_data       output word                              [WORD_SIZE]
//   busy         high while a packet grant is held (LOCKED)
//   grant_id     current or most recent grant holder
module tx_stream_arbiter #(
  parameter int unsigned NUM_REQUESTERS = 3,
  parameter int unsigned WORD_SIZE      = 8
) (
  input  logic                                 clk_system,
  input  logic                                 rstn_system,
  input  logic [NUM_REQUESTERS-1:0]            s_valid,
  output logic [NUM_REQUESTERS-1:0]            s_ready,
  input  logic [NUM_REQUESTERS*WORD_SIZE-1:0]  s_data,
  input  logic [NUM_REQUESTERS-1:0]            s_last,
  output logic                                 m_valid,
  input  logic                                 m_ready,
  output logic [WORD_SIZE-1:0]                 m_data,
  output logic                                 busy,
  output logic [$clog2(NUM_REQUESTERS)-1:0]    grant_id
);

  localparam int unsigned GW = $clog2(NUM_REQUESTERS);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t                 state, state_d;
  logic [GW-1:0]          last_grant, last_grant_d;
  logic [GW-1:0]          grant_d;
  logic                   m_valid_d;
  logic [WORD_SIZE-1:0]   m_data_d;

  // Granted source's signals
  logic [WORD_SIZE-1:0]   sel_data;
  logic                   sel_valid;
  logic                   sel_last;

  // Handshake helpers
  logic                   out_free;
  logic                   accept;

  // Round-robin search
  logic [GW:0]                  start;
  logic [2*NUM_REQUESTERS-1:0]  req_dbl;
  logic [2*NUM_REQUESTERS-1:0]  req_rot;
  logic [GW+1:0]                pick_sum;
  logic [GW-1:0]                pick;

  // Mux the granted requester's lane; compare-based so no index can exceed
  // the requester count when NUM_REQUESTERS is not a power of two.
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
      if (grant_id == GW'(i)) begin
        sel_data  = s_data[i*WORD_SIZE +: WORD_SIZE];
        sel_valid = s_valid[i];
        sel_last  = s_last[i];
      end
    end
  end

  // Output register can take a word when empty or draining this cycle.
  assign out_free = !m_valid || m_ready;
  assign accept   = (state == LOCKED) && out_free && sel_valid;
  assign busy     = (state == LOCKED);

  // s_ready depends only on state, grant_id, m_valid and m_ready.
  always_comb begin
    s_ready = '0;
    for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
      s_ready[i] = (state == LOCKED) && (grant_id == GW'(i)) && out_free;
    end
  end

  // Rotate a doubled request vector so bit 0 is requester last_grant+1, then
  // take the lowest set bit and map its offset back modulo NUM_REQUESTERS.
  always_comb begin
    start    = {1'b0, last_grant} + (GW+1)'(1);
    req_dbl  = {s_valid, s_valid};
    req_rot  = req_dbl >> start;
    pick_sum = '0;
    for (int unsigned j = NUM_REQUESTERS; j > 0; j--) begin
      if (req_rot[j-1]) begin
        pick_sum = (GW+2)'(start) + (GW+2)'(j-1);
      end
    end
    if (pick_sum >= (GW+2)'(NUM_REQUESTERS)) begin
      pick = GW'(pick_sum - (GW+2)'(NUM_REQUESTERS));
    end else begin
      pick = GW'(pick_sum);
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d      = state;
    grant_d      = grant_id;
    last_grant_d = last_grant;
    m_valid_d    = m_valid;
    m_data_d     = m_data;

    unique case (state)
      IDLE: begin
        if (|s_valid) begin
          grant_d = pick;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (accept && sel_last) begin
          last_grant_d = grant_id;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Accept reloads the register even while the old word drains; otherwise
    // a downstream take empties it and a stall holds it.
    if (accept) begin
      m_valid_d = 1'b1;
      m_data_d  = sel_data;
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_system or negedge rstn_system) begin
    if (!rstn_system) begin
      state      <= IDLE;
      grant_id   <= '0;
      last_grant <= GW'(NUM_REQUESTERS - 1);
      m_valid    <= 1'b0;
      m_data     <= '0;
    end else begin
      state      <= state_d;
      grant_id   <= grant_d;
      last_grant <= last_grant_d;
      m_valid    <= m_valid_d;
      m_data     <= m_data_d;
    end
  end

endmodule

// File: doc/tx_stream_arbiter.md
TX_STREAM_ARBITER -- requirements
Module: tx_stream_arbiter

Interface
REQ-001 Parameter NUM_REQUESTERS, default 3: number of byte-stream sources sharing the SPI TX channel; legal range is 2 to 8.
REQ-002 Parameter WORD_SIZE, default 8: width of each data word.
REQ-003 Port clk_system, input, 1 bit: the single clock; all logic is synchronous to its rising edge.
REQ-004 Port rstn_system, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port s_valid, input, NUM_REQUESTERS bits: per-requester word-valid signal.
REQ-006 Port s_ready, output, NUM_REQUESTERS bits: per-requester word-accepted signal.
REQ-007 Port s_data, input, NUM_REQUESTERS*WORD_SIZE bits: requester i's word occupies bits [i*WORD_SIZE +: WORD_SIZE].
REQ-008 Port s_last, input, NUM_REQUESTERS bits: per-requester flag marking the final word of a packet.
REQ-009 Port m_valid, output, 1 bit: output word valid, toward the SPI TX queue.
REQ-010 Port m_ready, input, 1 bit: SPI TX queue accepts the output word.
REQ-011 Port m_data, output, WORD_SIZE bits: output word.
REQ-012 Port busy, output, 1 bit: high while the state is LOCKED.
REQ-013 Port grant_id, output, $clog2(NUM_REQUESTERS) bits: index of the current or most recent grant holder.

Function
REQ-014 A transfer occurs on an interface in any cycle where its valid and ready are both high at the clock edge.
REQ-015 State machine:
- Two states: IDLE and LOCKED.
- Reset state is IDLE.
REQ-016 IDLE behaviour:
- If any s_valid bit is high, select the first high bit searching upward from (last_grant+1) modulo NUM_REQUESTERS.
- Register the selected index into grant_id and go to LOCKED.
- s_ready is all-zero in IDLE.
REQ-017 In LOCKED, s_ready[grant_id] = (!m_valid || m_ready); all other s_ready bits are 0.
REQ-018 On each accepted word, m_data is loaded with s_data[grant_id] and m_valid is set on the next edge.
REQ-019 When m_valid is high and m_ready is low, m_valid and m_data hold unchanged.
REQ-020 When m_ready is high and no new word is accepted in the same cycle, m_valid clears.
REQ-021 A word accepted with s_last high ends the packet:
- last_grant <= grant_id.
- The state returns to IDLE on the next edge.
REQ-022 The grant is held across gaps: s_valid[grant_id] may drop mid-packet without releasing the grant, and no timeout applies.
REQ-023 Changes on s_valid of non-granted requesters while LOCKED have no effect.
REQ-024 Latency and throughput:
- A request in IDLE at cycle N gives s_ready at cycle N+1 and m_valid at cycle N+2.
- With m_ready held high, sustained throughput is one word per cycle within a packet.
- There is one dead cycle (IDLE) between packets.
REQ-025 A single-word packet (s_last on the first word) is legal; the state returns to IDLE after exactly one transfer.
REQ-026 Words are never duplicated, dropped or reordered, and words from two packets are never interleaved.
REQ-027 s_ready is combinational from state, grant_id, m_valid and m_ready only, never from s_valid.

Reset
REQ-028 While rstn_system is low, outputs take these values:
- m_valid = 0, m_data = 0, s_ready = 0, busy = 0, grant_id = 0.
- The state is IDLE.
- last_grant = NUM_REQUESTERS-1, so requester 0 has first priority.
REQ-029 Reset asserted mid-packet discards the in-flight word and the grant.
REQ-030 After reset deasserts, the first grant follows the rule in REQ-016.

Verification
REQ-031 Reset, then s_valid=3'b111 held with 1-word packets -> grants issued in order 0,1,2,0; m_data matches each source; one IDLE cycle between packets.
REQ-032 Requester 1 sends a 4-word packet 0xA1..0xA4 while requester 0 asserts s_valid from the second word -> m_data = A1,A2,A3,A4, then requester 0's word; s_ready[0] stays 0 until the grant passes.
REQ-033 m_ready held low for 5 cycles with m_valid=1, m_data=0x5C -> m_data stable at 0x5C, s_ready all-zero, no word lost once m_ready returns high.
REQ-034 Granted requester 2 drops s_valid for 3 cycles mid-packet -> busy stays 1, grant_id stays 2, and the packet completes when s_valid returns.
REQ-035 rstn_system pulsed low mid-packet with m_valid=1 -> m_valid=0 and busy=0 immediately (asynchronously), and the next grant goes to requester 0 if requester 0 is requesting.
